// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control sequencer: ALUOp values, funct fields,
// registered operation codes and the MULT/DIV sequencing FSM states.
package alu_ctrl_pkg;

  localparam logic [3:0] AOP_RTYPE  = 4'b1111;
  localparam logic [3:0] AOP_ADDI   = 4'b0100;
  localparam logic [3:0] AOP_ORI    = 4'b0101;
  localparam logic [3:0] AOP_ANDI   = 4'b0110;
  localparam logic [3:0] AOP_LUI    = 4'b1000;
  localparam logic [3:0] AOP_BRANCH = 4'b0001;

  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;

  localparam logic [3:0] OP_AND     = 4'b0000;
  localparam logic [3:0] OP_OR      = 4'b0001;
  localparam logic [3:0] OP_NOR     = 4'b0010;
  localparam logic [3:0] OP_ADD     = 4'b0011;
  localparam logic [3:0] OP_SUB     = 4'b0100;
  localparam logic [3:0] OP_SLL     = 4'b0101;
  localparam logic [3:0] OP_SRL     = 4'b0110;
  localparam logic [3:0] OP_LUI     = 4'b0111;
  localparam logic [3:0] OP_MULT    = 4'b1000;
  localparam logic [3:0] OP_ILLEGAL = 4'b1001;
  localparam logic [3:0] OP_DIV     = 4'b1010;
  localparam logic [3:0] OP_MFHI    = 4'b1011;
  localparam logic [3:0] OP_MFLO    = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp + funct decode to a 4-bit operation code; flags the
// multi-cycle MULT/DIV operations so the sequencer can start its counter.
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 4
) (
  input  logic [ALUOP_W-1:0] alu_op_i,
  input  logic [5:0]         funct_i,
  output logic [3:0]         op_o,
  output logic               is_muldiv_o
);

  always_comb begin
    op_o        = OP_ILLEGAL;
    is_muldiv_o = 1'b0;
    // ALUOp constants are zero-extended, so any wider out-of-range value stays illegal
    if (alu_op_i == ALUOP_W'(AOP_RTYPE)) begin
      case (funct_i)
        FN_AND:  op_o = OP_AND;
        FN_OR:   op_o = OP_OR;
        FN_NOR:  op_o = OP_NOR;
        FN_ADD:  op_o = OP_ADD;
        FN_SUB:  op_o = OP_SUB;
        FN_SLL:  op_o = OP_SLL;
        FN_SRL:  op_o = OP_SRL;
        FN_MFHI: op_o = OP_MFHI;
        FN_MFLO: op_o = OP_MFLO;
        FN_MULT: begin
          op_o        = OP_MULT;
          is_muldiv_o = 1'b1;
        end
        FN_DIV: begin
          op_o        = OP_DIV;
          is_muldiv_o = 1'b1;
        end
        default: op_o = OP_ILLEGAL;
      endcase
    end else if (alu_op_i == ALUOP_W'(AOP_ADDI)) begin
      op_o = OP_ADD;
    end else if (alu_op_i == ALUOP_W'(AOP_ORI)) begin
      op_o = OP_OR;
    end else if (alu_op_i == ALUOP_W'(AOP_ANDI)) begin
      op_o = OP_AND;
    end else if (alu_op_i == ALUOP_W'(AOP_LUI)) begin
      op_o = OP_LUI;
    end else if (alu_op_i == ALUOP_W'(AOP_BRANCH)) begin
      op_o = OP_SUB;
    end
  end

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU control with MULT/DIV occupancy sequencing and upstream stall.
//   state | meaning
//   IDLE  | no multi-cycle op in flight, accepting instructions
//   BUSY  | MULT/DIV counting down, upstream stalled
//   DONE  | HI/LO write cycle, accepting instructions again
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W    = 4,
  parameter int OPER_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8,
  parameter int CNT_W      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_i,
  input  logic [ALUOP_W-1:0] alu_op_i,
  input  logic [5:0]         funct_i,
  input  logic               flush_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [OPER_W-1:0]  alu_operation_o,
  output logic               hilo_we_o,
  output logic               busy_o
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_valid;
  logic [OPER_W-1:0]  r_op;
  logic [3:0]         w_dec_op;
  logic               w_is_muldiv;
  logic               w_ready;
  logic               w_cap;

  alu_op_decode #(
    .ALUOP_W (ALUOP_W)
  ) u_decode (
    .alu_op_i    (alu_op_i),
    .funct_i     (funct_i),
    .op_o        (w_dec_op),
    .is_muldiv_o (w_is_muldiv)
  );

  assign w_ready = (r_state != ST_BUSY);
  assign w_cap   = valid_i && w_ready && !flush_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        w_state_nxt = ST_IDLE;
        if (w_cap && w_is_muldiv) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = (w_dec_op == OP_MULT) ? CNT_W'(MUL_CYCLES - 1)
                                              : CNT_W'(DIV_CYCLES - 1);
        end
      end
      ST_BUSY: begin
        if (flush_i) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    ready_o   = w_ready;
    busy_o    = (r_state == ST_BUSY);
    hilo_we_o = (r_state == ST_DONE);
  end

  // Op code holds across bubbles; only valid_o drops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_op    <= OPER_W'(OP_ILLEGAL);
    end else begin
      r_valid <= w_cap;
      if (w_cap) r_op <= OPER_W'(w_dec_op);
    end
  end

  assign valid_o         = r_valid;
  assign alu_operation_o = r_op;

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq: directed scenarios plus random
// stimulus against a cycle-indexed occupancy model of the sequencer.
module tb_alu_control_seq;

  localparam int MUL_N = 4;
  localparam int DIV_N = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid_i = 1'b0;
  logic [3:0] alu_op_i = 4'b0;
  logic [5:0] funct_i = 6'b0;
  logic       flush_i = 1'b0;
  logic       ready_o, valid_o, hilo_we_o, busy_o;
  logic [3:0] alu_operation_o;

  int n_checks = 0;
  int n_errors = 0;

  // Model: current cycle index, last busy cycle and HI/LO write cycle of the op in flight
  int         cyc = 0;
  int         busy_end = -1;
  int         done_cyc = -1;
  logic       m_valid = 1'b0;
  logic [3:0] m_op = 4'b1001;
  int         seen_busy = 0;
  int         seen_hilo = 0;

  logic [3:0] aop_tab [10];
  logic [5:0] fn_tab  [12];

  alu_control_seq #(
    .ALUOP_W    (4),
    .OPER_W     (4),
    .MUL_CYCLES (MUL_N),
    .DIV_CYCLES (DIV_N),
    .CNT_W      (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .valid_i         (valid_i),
    .alu_op_i        (alu_op_i),
    .funct_i         (funct_i),
    .flush_i         (flush_i),
    .ready_o         (ready_o),
    .valid_o         (valid_o),
    .alu_operation_o (alu_operation_o),
    .hilo_we_o       (hilo_we_o),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Decode table straight from the instruction set; occ is total EX occupancy
  function automatic void ref_dec(input logic [3:0] aop, input logic [5:0] fn,
                                  output logic [3:0] code, output int occ);
    occ  = 0;
    code = 4'b1001;
    case (aop)
      4'b0100: code = 4'b0011;
      4'b0101: code = 4'b0001;
      4'b0110: code = 4'b0000;
      4'b1000: code = 4'b0111;
      4'b0001: code = 4'b0100;
      4'b1111: begin
        case (fn)
          6'b100100: code = 4'b0000;
          6'b100101: code = 4'b0001;
          6'b100111: code = 4'b0010;
          6'b100000: code = 4'b0011;
          6'b100010: code = 4'b0100;
          6'b000000: code = 4'b0101;
          6'b000010: code = 4'b0110;
          6'b011000: begin code = 4'b1000; occ = MUL_N; end
          6'b011010: begin code = 4'b1010; occ = DIV_N; end
          6'b010000: code = 4'b1011;
          6'b010010: code = 4'b1100;
          default:   code = 4'b1001;
        endcase
      end
      default: code = 4'b1001;
    endcase
  endfunction

  task automatic model_reset();
    busy_end = -1;
    done_cyc = -1;
    m_valid  = 1'b0;
    m_op     = 4'b1001;
  endtask

  task automatic model_edge();
    logic       was_busy;
    logic [3:0] code;
    int         occ;
    was_busy = (cyc <= busy_end);
    cyc++;
    if (flush_i && was_busy) begin
      busy_end = cyc - 1;
      done_cyc = -1;
    end
    if (valid_i && !was_busy && !flush_i) begin
      ref_dec(alu_op_i, funct_i, code, occ);
      m_valid = 1'b1;
      m_op    = code;
      if (occ > 0) begin
        busy_end = cyc + occ - 2;
        done_cyc = cyc + occ - 1;
      end
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic e_busy;
    e_busy = (cyc <= busy_end);
    chk("valid_o", 32'(valid_o), 32'(m_valid));
    chk("alu_operation_o", 32'(alu_operation_o), 32'(m_op));
    chk("ready_o", 32'(ready_o), 32'(!e_busy));
    chk("busy_o", 32'(busy_o), 32'(e_busy));
    chk("hilo_we_o", 32'(hilo_we_o), 32'(cyc == done_cyc));
    if (busy_o === 1'b1) seen_busy++;
    if (hilo_we_o === 1'b1) seen_hilo++;
  endtask

  // Called at a falling edge: drive, clock, update model, check at next falling edge
  task automatic step(input logic v, input logic [3:0] aop, input logic [5:0] fn, input logic fl);
    valid_i  = v;
    alu_op_i = aop;
    funct_i  = fn;
    flush_i  = fl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 4'b0000, 6'b000000, 1'b0);
  endtask

  initial begin
    aop_tab = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0100,
                4'b0101, 4'b0110, 4'b1000, 4'b0001, 4'b0011};
    fn_tab  = '{6'b100100, 6'b100101, 6'b100111, 6'b100000, 6'b100010, 6'b000000,
                6'b000010, 6'b011000, 6'b011010, 6'b010000, 6'b010010, 6'b111111};

    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    reset = 1'b1;
    idle(1);

    // ADD then ORI back to back
    step(1'b1, 4'b1111, 6'b100000, 1'b0);
    step(1'b1, 4'b0101, 6'b101010, 1'b0);
    idle(1);

    // MULT occupancy
    seen_busy = 0;
    seen_hilo = 0;
    step(1'b1, 4'b1111, 6'b011000, 1'b0);
    idle(4);
    chk("mult_busy_cycles", 32'(seen_busy), 32'd3);
    chk("mult_hilo_pulses", 32'(seen_hilo), 32'd1);

    // DIV with MFHI held at the input until accepted
    step(1'b1, 4'b1111, 6'b011010, 1'b0);
    for (int k = 0; k < DIV_N; k++) step(1'b1, 4'b1111, 6'b010000, 1'b0);
    chk("mfhi_after_div", 32'(alu_operation_o), 32'hb);
    idle(1);

    // DIV flushed in its third busy cycle
    seen_hilo = 0;
    step(1'b1, 4'b1111, 6'b011010, 1'b0);
    idle(2);
    step(1'b0, 4'b0000, 6'b000000, 1'b1);
    chk("flush_busy_clear", 32'(busy_o), 32'd0);
    idle(DIV_N);
    chk("flush_no_hilo", 32'(seen_hilo), 32'd0);

    // Illegal R-type, then async reset in the middle of a DIV
    step(1'b1, 4'b1111, 6'b111111, 1'b0);
    seen_hilo = 0;
    step(1'b1, 4'b1111, 6'b011010, 1'b0);
    idle(2);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", 32'(valid_o), 32'd0);
    chk("async_rst_op", 32'(alu_operation_o), 32'h9);
    chk("async_rst_ready", 32'(ready_o), 32'd1);
    chk("async_rst_busy", 32'(busy_o), 32'd0);
    chk("async_rst_hilo", 32'(hilo_we_o), 32'd0);
    model_reset();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    reset = 1'b1;
    idle(DIV_N + 2);
    chk("rst_no_hilo", 32'(seen_hilo), 32'd0);

    // Random traffic
    for (int k = 0; k < 800; k++) begin
      logic [3:0] a;
      logic [5:0] f;
      a = aop_tab[$urandom_range(0, 9)];
      if ($urandom_range(0, 15) == 0) a = 4'($urandom);
      f = fn_tab[$urandom_range(0, 11)];
      if ($urandom_range(0, 7) == 0) f = 6'($urandom);
      step(1'($urandom_range(0, 9) < 8), a, f, 1'($urandom_range(0, 19) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
